// File: rtl/rr_grant_tracker.sv
// Holds the 4-way round-robin arbiter's one-hot grant for a burst, drives the rotation pointer, and blanks grant_in while the arbiter settles.
// Optional idle-beat watchdog enabled by defining GRANT_TIMEOUT_EN.
module rr_grant_tracker #(
  parameter int BURST_W = 4,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [3:0]           grant_in,
  input  logic [4*BURST_W-1:0] burst_len,
  input  logic                 beat,
  output logic [1:0]           ptr,
  output logic [3:0]           grant_out,
  output logic [1:0]           grant_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 abort,
  output logic                 onehot_err,
  output logic                 timeout
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]         state;
  logic [BURST_W-1:0] beats_left;
  logic [SW-1:0]      settle_cnt;

  logic               gi_multi, gi_hit;
  logic [1:0]         gi_idx;
  logic [BURST_W-1:0] sel_len;
  logic               fin, own_req, rel_done, rel_abort, rel_to, rel;

  always_comb begin
    gi_multi = |(grant_in & (grant_in - 4'd1));
    gi_idx   = 2'd0;
    sel_len  = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_in[i]) begin
        gi_idx  = 2'(i);
        sel_len = burst_len[i*BURST_W +: BURST_W];
      end
    end
    gi_hit = (grant_in != 4'd0) && !gi_multi && req[gi_idx];
  end

  // Final beat outranks a simultaneous req drop; abort outranks the watchdog.
  assign fin       = beat && (beats_left == '0);
  assign own_req   = req[grant_idx];
  assign rel_done  = fin;
  assign rel_abort = !fin && !own_req;
  assign rel       = rel_done || rel_abort || rel_to;

`ifdef GRANT_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] wdog;
  assign rel_to = !beat && own_req && (wdog == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign rel_to         = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= 2'd0;
      grant_out  <= 4'd0;
      grant_idx  <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      onehot_err <= 1'b0;
      beats_left <= '0;
      settle_cnt <= '0;
`ifdef GRANT_TIMEOUT_EN
      timeout    <= 1'b0;
      wdog       <= '0;
`endif
    end else begin
      done       <= 1'b0;
      abort      <= 1'b0;
      onehot_err <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (gi_multi) begin
            onehot_err <= 1'b1;
          end else if (gi_hit) begin
            grant_out  <= grant_in;
            grant_idx  <= gi_idx;
            busy       <= 1'b1;
            beats_left <= sel_len;
            state      <= S_HOLD;
`ifdef GRANT_TIMEOUT_EN
            wdog       <= '0;
`endif
          end
        end
        S_HOLD: begin
          if (rel) begin
            grant_out <= 4'd0;
            busy      <= 1'b0;
            ptr       <= grant_idx + 2'd1;
            done      <= rel_done;
            abort     <= rel_abort;
`ifdef GRANT_TIMEOUT_EN
            timeout   <= rel_to && !rel_abort;
`endif
            if (SETTLE == 0) begin
              state <= S_IDLE;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= SW'(SETTLE - 1);
            end
          end else begin
            if (beat) beats_left <= beats_left - 1'b1;
`ifdef GRANT_TIMEOUT_EN
            wdog <= beat ? '0 : wdog + 1'b1;
`endif
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_IDLE;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_grant_tracker.sv
// Directed bench for rr_grant_tracker at default parameters; timeout expectations follow GRANT_TIMEOUT_EN.
module tb_rr_grant_tracker;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, grant_in;
  logic [15:0] burst_len;
  logic        beat;
  logic [1:0]  ptr, grant_idx;
  logic [3:0]  grant_out;
  logic        busy, done, abort, onehot_err, timeout;
  int          total = 0;
  int          bad = 0;

  rr_grant_tracker dut (
    .clk(clk), .reset(reset), .req(req), .grant_in(grant_in),
    .burst_len(burst_len), .beat(beat), .ptr(ptr), .grant_out(grant_out),
    .grant_idx(grant_idx), .busy(busy), .done(done), .abort(abort),
    .onehot_err(onehot_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req = 4'd0; grant_in = 4'd0; burst_len = 16'h0; beat = 1'b0;
    tick(); tick();
    chk("rst_ptr", 32'(ptr), 0);
    chk("rst_gout", 32'(grant_out), 0);
    chk("rst_idx", 32'(grant_idx), 0);
    chk("rst_flags", {busy, done, abort, onehot_err, timeout}, 0);
    reset = 1'b0;

    // owner 2, three beats
    req = 4'b0100; grant_in = 4'b0100; burst_len = 16'h0200; beat = 1'b1;
    tick();
    chk("t1_gout", 32'(grant_out), 32'h4);
    chk("t1_idx", 32'(grant_idx), 2);
    chk("t1_busy", 32'(busy), 1);
    tick(); chk("t1_b1", {grant_out, done}, {4'b0100, 1'b0});
    tick(); chk("t1_b2", {grant_out, done}, {4'b0100, 1'b0});
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_ptr", 32'(ptr), 3);
    chk("t1_gout0", 32'(grant_out), 0);
    chk("t1_busy0", 32'(busy), 0);
    beat = 1'b0;
    tick(); chk("t1_s1", {grant_out, done}, 0);
    tick(); chk("t1_s2", 32'(grant_out), 0);
    tick(); chk("t1_s3", 32'(grant_out), 0);
    tick(); chk("t1_regrant", 32'(grant_out), 32'h4);
    grant_in = 4'd0; beat = 1'b1;
    tick(); tick(); tick();
    chk("t1_done2", {done, ptr}, {1'b1, 2'd3});
    beat = 1'b0;
    tick(); tick(); tick();

    // owner 3, one beat, ptr wraps; multi-hot ignored in SETTLE, flagged in IDLE
    req = 4'b1000; grant_in = 4'b1000; burst_len = 16'h0000;
    tick(); chk("t2_gout", {grant_out, grant_idx}, {4'b1000, 2'd3});
    grant_in = 4'b0011; beat = 1'b1;
    tick(); chk("t2_wrap", {done, ptr}, {1'b1, 2'd0});
    beat = 1'b0; req = 4'b0011;
    tick(); chk("t2_sett_err1", 32'(onehot_err), 0);
    tick(); chk("t2_sett_err2", 32'(onehot_err), 0);
    tick(); chk("t2_sett_err3", 32'(onehot_err), 0);
    tick();
    chk("t2_err", 32'(onehot_err), 1);
    chk("t2_gout0", {grant_out, busy, ptr}, 0);
    grant_in = 4'd0;
    tick(); chk("t2_errpulse", 32'(onehot_err), 0);

    // stale grant then accept
    req = 4'b0001; grant_in = 4'b0010; burst_len = 16'h0050;
    tick(); chk("t3_stale", {grant_out, busy, onehot_err, done, abort}, 0);
    req = 4'b0010;
    tick(); chk("t3_accept", {grant_out, grant_idx, busy}, {4'b0010, 2'd1, 1'b1});

    // abort after two beats
    grant_in = 4'd0; beat = 1'b1;
    tick(); tick();
    chk("t4_hold", {busy, done, abort}, 3'b100);
    req = 4'b0000; beat = 1'b0;
    tick();
    chk("t4_abort", {abort, done, ptr, grant_out}, {1'b1, 1'b0, 2'd2, 4'd0});
    tick(); chk("t4_abortpulse", 32'(abort), 0);
    tick(); tick();
    // req drop on final beat completes normally
    req = 4'b0010; grant_in = 4'b0010;
    tick(); chk("t4b_accept", 32'(grant_out), 32'h2);
    grant_in = 4'd0; beat = 1'b1;
    repeat (5) tick();
    chk("t4b_hold", {busy, done}, 2'b10);
    req = 4'b0000;
    tick();
    chk("t4b_done", {done, abort, ptr, busy}, {1'b1, 1'b0, 2'd2, 1'b0});
    beat = 1'b0;
    tick(); tick(); tick();

    // reset mid-burst with beats_left=3
    req = 4'b0001; grant_in = 4'b0001; burst_len = 16'h0005;
    tick(); chk("t5_accept", 32'(grant_out), 32'h1);
    beat = 1'b1;
    tick(); tick();
    reset = 1'b1; beat = 1'b0;
    tick();
    chk("t5_rst", {ptr, grant_out, busy, done, abort, onehot_err, timeout}, 0);
    reset = 1'b0;

    // one beat then stall for the watchdog
    tick(); chk("t6_accept", 32'(grant_out), 32'h1);
    grant_in = 4'd0; beat = 1'b1;
    tick();
    beat = 1'b0;
    repeat (14) tick();
    chk("t6_pre", {busy, timeout}, 2'b10);
    tick();
`ifdef GRANT_TIMEOUT_EN
    chk("t6_to", {timeout, busy, done, abort, ptr}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd1});
    tick(); chk("t6_topulse", 32'(timeout), 0);
`else
    chk("t6_noto", {timeout, busy, ptr, grant_out}, {1'b0, 1'b1, 2'd0, 4'b0001});
    repeat (10) tick();
    chk("t6_still", {timeout, busy}, 2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
